// File: rtl/mc_main_control_if.sv
// Control bus between the multicycle main controller and the MIPS datapath.
// The controller is the master: it consumes opcode/zero and drives every select and enable.
interface mc_main_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic [3:0] state;
  logic       iord;
  logic       ir_write;
  logic       mem_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       branch;
  logic       pc_write;
  logic       pc_en;

  modport master (
    input  opcode, zero,
    output state, iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, branch, pc_write, pc_en
  );

  modport slave (
    output opcode, zero,
    input  state, iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, branch, pc_write, pc_en
  );
endinterface

// File: rtl/mc_main_control.sv
// Moore main controller for the multicycle MIPS datapath: sequences FETCH..writeback
// and registers the per-state control word alongside the state itself.
module mc_main_control (
  input  logic                  clk,
  input  logic                  rst_n,
  mc_main_control_if.master     bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,  DECODE   = 4'd1,  MEMADR  = 4'd2,  MEMRD  = 4'd3,
    MEMWB    = 4'd4,  MEMWR    = 4'd5,  EXECUTE = 4'd6,  ALUWB  = 4'd7,
    BRANCH   = 4'd8,  ADDIEXEC = 4'd9,  ADDIWB  = 4'd10, JUMP   = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       branch;
    logic       pc_write;
  } ctrl_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  function automatic state_t next_state(input state_t s, input logic [5:0] op);
    case (s)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYP:      next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEXEC;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      // IR still holds the opcode here, so lw/sw split one cycle late.
      MEMADR:   next_state = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    next_state = MEMWB;
      EXECUTE:  next_state = ALUWB;
      ADDIEXEC: next_state = ADDIWB;
      default:  next_state = FETCH;
    endcase
  endfunction

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.alu_src_b = 2'b01; end
      DECODE:   c.alu_src_b = 2'b11;
      MEMADR:   begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:    c.iord = 1'b1;
      MEMWB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      MEMWR:    begin c.iord = 1'b1; c.mem_write = 1'b1; end
      EXECUTE:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      ALUWB:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      BRANCH:   begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1'b1;
      end
      ADDIEXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ADDIWB:   c.reg_write = 1'b1;
      JUMP:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t state_q;
  state_t nxt;
  ctrl_t  ctrl_q;

  assign nxt = next_state(state_q, bus.opcode);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ctrl_q  <= decode(FETCH);
    end else begin
      state_q <= nxt;
      ctrl_q  <= decode(nxt);
    end
  end

  assign bus.state      = state_q;
  assign bus.iord       = ctrl_q.iord;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.alu_op     = ctrl_q.alu_op;
  assign bus.pc_src     = ctrl_q.pc_src;

  // Enables are gated by rst_n directly so nothing writes while reset is held,
  // even though the registered word already shows FETCH.
  assign bus.ir_write   = ctrl_q.ir_write  & rst_n;
  assign bus.mem_write  = ctrl_q.mem_write & rst_n;
  assign bus.reg_write  = ctrl_q.reg_write & rst_n;
  assign bus.pc_write   = ctrl_q.pc_write  & rst_n;
  assign bus.branch     = ctrl_q.branch    & rst_n;
  assign bus.pc_en      = rst_n & (ctrl_q.pc_write | (ctrl_q.branch & bus.zero));
endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: walks every instruction class, reset and
// mid-instruction reset, comparing state and the full control word each cycle.
module tb_mc_main_control;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;

  mc_main_control_if bus ();

  mc_main_control dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  always #5 clk = ~clk;

  // Control word order: iord,ir_write,mem_write,reg_dst,mem_to_reg,reg_write,alu_src_a,
  // alu_src_b[1:0],alu_op[1:0],pc_src[1:0],branch,pc_write
  function automatic logic [15:0] exp_ctrl(input logic [3:0] s);
    case (s)
      4'd0:  exp_ctrl = {1'b0, 7'b0100000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1};
      4'd1:  exp_ctrl = {1'b0, 7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
      4'd2:  exp_ctrl = {1'b0, 7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
      4'd3:  exp_ctrl = {1'b0, 7'b1000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      4'd4:  exp_ctrl = {1'b0, 7'b0000110, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      4'd5:  exp_ctrl = {1'b0, 7'b1010000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      4'd6:  exp_ctrl = {1'b0, 7'b0000001, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
      4'd7:  exp_ctrl = {1'b0, 7'b0001010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      4'd8:  exp_ctrl = {1'b0, 7'b0000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
      4'd9:  exp_ctrl = {1'b0, 7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
      4'd10: exp_ctrl = {1'b0, 7'b0000010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
      4'd11: exp_ctrl = {1'b0, 7'b0000000, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1};
      default: exp_ctrl = 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] obs_ctrl();
    obs_ctrl = {1'b0, bus.iord, bus.ir_write, bus.mem_write, bus.reg_dst, bus.mem_to_reg,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
                bus.branch, bus.pc_write};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check state, full control word and pc_en for the current cycle, then advance.
  task automatic cyc(input logic [3:0] s);
    logic [15:0] e;
    logic        pe;
    e  = exp_ctrl(s);
    pe = e[0] | (e[1] & bus.zero);
    chk($sformatf("state(exp %0d)", s), {12'd0, bus.state}, {12'd0, s});
    chk($sformatf("ctrl(st %0d)", s), obs_ctrl(), e);
    chk($sformatf("pc_en(st %0d)", s), {15'd0, bus.pc_en}, {15'd0, pe});
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.opcode = 6'b100011;
    bus.zero   = 1'b1;
    tick(); tick(); tick();

    chk("rst_state", {12'd0, bus.state}, 16'd0);
    chk("rst_enables", {11'd0, bus.ir_write, bus.mem_write, bus.reg_write, bus.pc_write,
                        bus.pc_en}, 16'd0);
    chk("rst_branch", {15'd0, bus.branch}, 16'd0);
    chk("rst_alu_src_b", {14'd0, bus.alu_src_b}, 16'd1);

    rst_n = 1'b1;
    bus.zero = 1'b0;
    #1;
    // lw: 0,1,2,3,4 then back to FETCH
    cyc(4'd0); cyc(4'd1); cyc(4'd2); cyc(4'd3); cyc(4'd4);

    bus.opcode = 6'b101011;
    cyc(4'd0); cyc(4'd1); cyc(4'd2); cyc(4'd5);

    bus.opcode = 6'b000000;
    bus.zero   = 1'b1;
    cyc(4'd0); cyc(4'd1); cyc(4'd6); cyc(4'd7);

    bus.opcode = 6'b000100;
    bus.zero   = 1'b1;
    cyc(4'd0); cyc(4'd1);
    chk("beq_taken_pc_en", {15'd0, bus.pc_en}, 16'd1);
    cyc(4'd8);

    bus.zero = 1'b0;
    cyc(4'd0); cyc(4'd1);
    chk("beq_not_taken_pc_en", {15'd0, bus.pc_en}, 16'd0);
    cyc(4'd8);

    bus.opcode = 6'b001000;
    cyc(4'd0); cyc(4'd1); cyc(4'd9); cyc(4'd10);

    bus.opcode = 6'b000010;
    cyc(4'd0); cyc(4'd1);
    chk("j_pc_en", {15'd0, bus.pc_en}, 16'd1);
    cyc(4'd11);

    bus.opcode = 6'b111111;
    cyc(4'd0); cyc(4'd1);

    // opcode wiggle outside DECODE must not disturb the lw sequence
    bus.opcode = 6'b100011;
    cyc(4'd0); cyc(4'd1);
    bus.opcode = 6'b000010;
    cyc(4'd2);
    bus.opcode = 6'b100011;
    chk("midrst_in_memrd", {12'd0, bus.state}, 16'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_reg_write", {15'd0, bus.reg_write}, 16'd0);
    chk("midrst_ir_write", {15'd0, bus.ir_write}, 16'd0);
    tick();
    chk("midrst_state", {12'd0, bus.state}, 16'd0);
    chk("midrst_reg_write2", {15'd0, bus.reg_write}, 16'd0);
    tick();
    rst_n = 1'b1;
    #1;
    cyc(4'd0); cyc(4'd1); cyc(4'd2); cyc(4'd3); cyc(4'd4); cyc(4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
